// File: rtl/agc_uplink_pkg.sv
// Shared types and constants for the AGC ground uplink transmitter.
package agc_uplink_pkg;

    localparam int UPLINK_DATA_BITS = 15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        SPACE = 2'd2,
        GAP   = 2'd3
    } uplink_state_t;

    // DSKY keycodes as the AGC keyboard decoder expects them
    localparam logic [4:0] KEY_0 = 5'b10000;
    localparam logic [4:0] VERB  = 5'b10001;
    localparam logic [4:0] NOUN  = 5'b11111;
    localparam logic [4:0] ENTR  = 5'b11100;

    // Keycode triple: the AGC checks k, ~k, k to reject corrupted uplink keys
    function automatic logic [UPLINK_DATA_BITS-1:0] make_key_word(input logic [4:0] k);
        return {k, ~k, k};
    endfunction

endpackage

// File: rtl/agc_uplink_timer.sv
// Loadable down-counter with terminal-count flag; times pulse, space and gap.
module agc_uplink_timer #(
    parameter int W = 16
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_tc
);

    logic [W-1:0] r_cnt;

    // Load wins; otherwise count down and park at zero
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_tc = (r_cnt == '0);

endmodule

// File: rtl/agc_uplink_tx.sv
// Ground-side uplink transmitter: serialises keycode triples or raw words
// MSB-first as UPL1/UPL0 pulses paced for the AGC INLINK counter.
module agc_uplink_tx
    import agc_uplink_pkg::*;
#(
    parameter int BIT_PERIOD  = 8000,
    parameter int PULSE_WIDTH = 50,
    parameter int WORD_GAP    = 40000,
    parameter int LEAD_ONE    = 1
) (
    input  logic        SIM_CLK,
    input  logic        SIM_RST_n,
    input  logic        word_valid,
    output logic        word_ready,
    input  logic        raw_mode,
    input  logic [4:0]  key_code,
    input  logic [14:0] raw_word,
    input  logic        BLKUPL_n,
    output logic        UPL0,
    output logic        UPL1,
    output logic        busy,
    output logic [7:0]  words_sent
);

    localparam int TMAX  = (BIT_PERIOD > WORD_GAP) ? BIT_PERIOD : WORD_GAP;
    localparam int TW    = $clog2(TMAX + 1);
    localparam int NBITS = (LEAD_ONE != 0) ? UPLINK_DATA_BITS + 1 : UPLINK_DATA_BITS;
    localparam logic   LEAD     = (LEAD_ONE != 0);
    localparam logic [TW-1:0] PULSE_LD = TW'(PULSE_WIDTH - 1);
    localparam logic [TW-1:0] SPACE_LD = TW'(BIT_PERIOD - PULSE_WIDTH - 1);
    localparam logic [TW-1:0] GAP_LD   = TW'((WORD_GAP > 0) ? WORD_GAP - 1 : 0);

    uplink_state_t r_state;
    logic [14:0]   r_shreg;      // bits still to send after the one on the wire
    logic [4:0]    r_bitcnt;     // pulses remaining including the current one
    logic          r_upl0;
    logic          r_upl1;
    logic          r_ready;
    logic [7:0]    r_words;

    logic          w_xfer;
    logic [14:0]   w_word;
    logic          w_first;
    logic          w_load;
    logic [TW-1:0] w_load_val;
    logic          w_tc;

    assign w_xfer  = word_valid & r_ready;
    assign w_word  = raw_mode ? raw_word : make_key_word(key_code);
    assign w_first = LEAD ? 1'b1 : w_word[14];

    // Reload the shared timer on every phase entry
    always_comb begin
        w_load     = 1'b0;
        w_load_val = PULSE_LD;
        case (r_state)
            IDLE: begin
                if (w_xfer) begin
                    w_load     = 1'b1;
                    w_load_val = PULSE_LD;
                end
            end
            PULSE: begin
                if (w_tc) begin
                    w_load     = 1'b1;
                    w_load_val = SPACE_LD;
                end
            end
            SPACE: begin
                if (w_tc) begin
                    w_load     = 1'b1;
                    w_load_val = (r_bitcnt == 5'd1) ? GAP_LD : PULSE_LD;
                end
            end
            default: ;
        endcase
    end

    agc_uplink_timer #(.W(TW)) u_timer (
        .i_clk      (SIM_CLK),
        .i_rst_n    (SIM_RST_n),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_tc       (w_tc)
    );

    // Word sequencer with registered pulse, ready and count outputs.
    // The first bit (lead-one or data MSB) is driven straight from the load,
    // so the shift register only holds the bits that follow it.
    always_ff @(posedge SIM_CLK or negedge SIM_RST_n) begin
        if (!SIM_RST_n) begin
            r_state  <= IDLE;
            r_shreg  <= '0;
            r_bitcnt <= '0;
            r_upl0   <= 1'b0;
            r_upl1   <= 1'b0;
            r_ready  <= 1'b0;
            r_words  <= '0;
        end else begin
            // Blocking only takes effect at a word boundary: ready is never
            // raised outside IDLE, so an active word always finishes intact
            r_ready <= (r_state == IDLE) && BLKUPL_n && !w_xfer;
            case (r_state)
                IDLE: begin
                    if (w_xfer) begin
                        r_shreg  <= LEAD ? w_word : {w_word[13:0], 1'b0};
                        r_bitcnt <= 5'(NBITS);
                        r_upl1   <= w_first;
                        r_upl0   <= ~w_first;
                        r_state  <= PULSE;
                    end
                end
                PULSE: begin
                    if (w_tc) begin
                        r_upl0  <= 1'b0;
                        r_upl1  <= 1'b0;
                        r_state <= SPACE;
                    end
                end
                SPACE: begin
                    if (w_tc) begin
                        r_shreg  <= r_shreg << 1;
                        r_bitcnt <= r_bitcnt - 5'd1;
                        if (r_bitcnt != 5'd1) begin
                            r_upl1  <= r_shreg[14];
                            r_upl0  <= ~r_shreg[14];
                            r_state <= PULSE;
                        end else begin
                            r_words <= r_words + 8'd1;
                            r_state <= GAP;
                        end
                    end
                end
                GAP: begin
                    if (w_tc) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign UPL0       = r_upl0;
    assign UPL1       = r_upl1;
    assign word_ready = r_ready;
    assign busy       = (r_state != IDLE);
    assign words_sent = r_words;

endmodule
